// File: rtl/commit_trace_buf_if.sv
// Write-back, event-pulse and drain-handshake bundle of commit_trace_buf.
interface commit_trace_buf_if #(
    parameter int DEPTH   = 16,
    parameter int PC_WD   = 64,
    parameter int INST_WD = 32
);
    localparam int CNT_WD = $clog2(DEPTH) + 1;

    logic               ws_valid;
    logic [PC_WD-1:0]   ws_pc;
    logic [INST_WD-1:0] ws_inst;
    logic               ws_exp;
    logic               ws_mret;
    logic               ws_out_of_mem;
    logic               stop;
    logic               icache_miss_pulse;
    logic               dcache_miss_pulse;
    logic               rd_req;

    logic               rd_valid;
    logic [PC_WD-1:0]   rd_pc;
    logic [INST_WD-1:0] rd_inst;
    logic [2:0]         rd_flags;
    logic               frozen;
    logic [CNT_WD-1:0]  entry_cnt;
    logic [63:0]        cycle_cnt;
    logic [63:0]        retire_cnt;
    logic [31:0]        icache_miss_cnt;
    logic [31:0]        dcache_miss_cnt;

    modport master (
        output ws_valid, ws_pc, ws_inst, ws_exp, ws_mret, ws_out_of_mem, stop,
               icache_miss_pulse, dcache_miss_pulse, rd_req,
        input  rd_valid, rd_pc, rd_inst, rd_flags, frozen, entry_cnt,
               cycle_cnt, retire_cnt, icache_miss_cnt, dcache_miss_cnt
    );

    modport slave (
        input  ws_valid, ws_pc, ws_inst, ws_exp, ws_mret, ws_out_of_mem, stop,
               icache_miss_pulse, dcache_miss_pulse, rd_req,
        output rd_valid, rd_pc, rd_inst, rd_flags, frozen, entry_cnt,
               cycle_cnt, retire_cnt, icache_miss_cnt, dcache_miss_cnt
    );
endinterface

// File: rtl/commit_trace_buf.sv
// Retirement trace ring buffer with cycle/retire/cache-miss counters and a post-halt drain port.
// Optional macro COMMIT_TRACE_OOM_HALT_EN: an out-of-memory retirement halts like stop.
module commit_trace_buf #(
    parameter int DEPTH   = 16,
    parameter int PC_WD   = 64,
    parameter int INST_WD = 32
) (
    input logic               clk,
    input logic               reset,
    commit_trace_buf_if.slave trace_io
);
    localparam int PTR_WD = $clog2(DEPTH);
    localparam int CNT_WD = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {RUN, FROZEN, DRAIN, DONE} state_e;

    typedef struct packed {
        logic [PC_WD-1:0]   pc;
        logic [INST_WD-1:0] inst;
        logic [2:0]         flags;
    } entry_t;

    entry_t            mem_q [DEPTH];
    state_e            state_q, state_d;
    logic [PTR_WD-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WD-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WD-1:0] cnt_q, cnt_d;
    logic [63:0]       cycle_q, cycle_d;
    logic [63:0]       retire_q, retire_d;
    logic [31:0]       icache_q, icache_d;
    logic [31:0]       dcache_q, dcache_d;
    logic              rd_valid_q, rd_valid_d;
    entry_t            rd_entry_q, rd_entry_d;
    logic              mem_we;
    entry_t            wr_entry;
    logic              halt_req;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        cycle_d    = cycle_q;
        retire_d   = retire_q;
        icache_d   = icache_q;
        dcache_d   = dcache_q;
        rd_valid_d = 1'b0;
        rd_entry_d = rd_entry_q;
        mem_we     = 1'b0;
        wr_entry   = '{pc: trace_io.ws_pc, inst: trace_io.ws_inst,
                       flags: {trace_io.ws_out_of_mem, trace_io.ws_mret, trace_io.ws_exp}};
`ifdef COMMIT_TRACE_OOM_HALT_EN
        halt_req   = trace_io.stop | (trace_io.ws_valid & trace_io.ws_out_of_mem);
`else
        halt_req   = trace_io.stop;
`endif

        unique case (state_q)
            RUN: begin
                cycle_d = cycle_q + 64'd1;
                if (trace_io.ws_valid) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_WD'(1);
                    retire_d = retire_q + 64'd1;
                    // A full ring drops its oldest entry so it always holds the latest history.
                    if (cnt_q == CNT_WD'(DEPTH)) begin
                        rd_ptr_d = rd_ptr_q + PTR_WD'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_WD'(1);
                    end
                end
                if (halt_req) begin
                    state_d = FROZEN;
                end
            end
            FROZEN, DRAIN: begin
                if (trace_io.rd_req) begin
                    if (cnt_q != '0) begin
                        rd_valid_d = 1'b1;
                        rd_entry_d = mem_q[rd_ptr_q];
                        rd_ptr_d   = rd_ptr_q + PTR_WD'(1);
                        cnt_d      = cnt_q - CNT_WD'(1);
                        state_d    = DRAIN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
            end
        endcase

        if (state_q != DONE) begin
            if (trace_io.icache_miss_pulse && (icache_q != 32'hFFFF_FFFF)) begin
                icache_d = icache_q + 32'd1;
            end
            if (trace_io.dcache_miss_pulse && (dcache_q != 32'hFFFF_FFFF)) begin
                dcache_d = dcache_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            cycle_q    <= '0;
            retire_q   <= '0;
            icache_q   <= '0;
            dcache_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_entry_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            cycle_q    <= cycle_d;
            retire_q   <= retire_d;
            icache_q   <= icache_d;
            dcache_q   <= dcache_d;
            rd_valid_q <= rd_valid_d;
            rd_entry_q <= rd_entry_d;
        end
    end

    // Storage needs no reset: entries are only read while cnt_q says they are valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign trace_io.rd_valid        = rd_valid_q;
    assign trace_io.rd_pc           = rd_entry_q.pc;
    assign trace_io.rd_inst         = rd_entry_q.inst;
    assign trace_io.rd_flags        = rd_entry_q.flags;
    assign trace_io.frozen          = (state_q != RUN);
    assign trace_io.entry_cnt       = cnt_q;
    assign trace_io.cycle_cnt       = cycle_q;
    assign trace_io.retire_cnt      = retire_q;
    assign trace_io.icache_miss_cnt = icache_q;
    assign trace_io.dcache_miss_cnt = dcache_q;
endmodule

// File: tb/tb_commit_trace_buf.sv
// Scoreboard bench for commit_trace_buf: stimulus pushes expected drain entries, a monitor pops and compares.
module tb_commit_trace_buf;
    localparam int DEPTH   = 16;
    localparam int PC_WD   = 64;
    localparam int INST_WD = 32;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [2:0]  flags;
    } entry_t;

    logic   clk = 1'b0;
    logic   reset;
    entry_t expQ[$];
    entry_t monEntry;
    int     errors = 0;
    int     checks = 0;

    always #5 clk = ~clk;

    commit_trace_buf_if #(.DEPTH(DEPTH), .PC_WD(PC_WD), .INST_WD(INST_WD)) bus ();

    commit_trace_buf #(.DEPTH(DEPTH), .PC_WD(PC_WD), .INST_WD(INST_WD)) dut (
        .clk      (clk),
        .reset    (reset),
        .trace_io (bus)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    // Monitor: every cycle the DUT presents a popped entry, it must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("rd_valid_unexpected", 64'd1, 64'd0);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("rd_pc", bus.rd_pc, monEntry.pc);
                checkOutput("rd_inst", 64'(bus.rd_inst), 64'(monEntry.inst));
                checkOutput("rd_flags", 64'(bus.rd_flags), 64'(monEntry.flags));
            end
        end
    end

    function automatic entry_t makeEntry(input int k, input logic [2:0] flags);
        entry_t e;
        e.pc    = 64'h8000_0000 + 64'(4 * k);
        e.inst  = 32'h1000_0000 + 32'(k);
        e.flags = flags;
        return e;
    endfunction

    // Drives one cycle of inputs, then returns 1 time unit after the edge with everything idle.
    task automatic applyStimulus(input logic valid, input entry_t e, input logic stopIn,
                                 input logic ic, input logic dc, input logic req);
        bus.ws_valid          = valid;
        bus.ws_pc             = e.pc;
        bus.ws_inst           = e.inst;
        bus.ws_out_of_mem     = e.flags[2];
        bus.ws_mret           = e.flags[1];
        bus.ws_exp            = e.flags[0];
        bus.stop              = stopIn;
        bus.icache_miss_pulse = ic;
        bus.dcache_miss_pulse = dc;
        bus.rd_req            = req;
        @(posedge clk);
        #1;
        bus.ws_valid          = 1'b0;
        bus.ws_pc             = '0;
        bus.ws_inst           = '0;
        bus.ws_out_of_mem     = 1'b0;
        bus.ws_mret           = 1'b0;
        bus.ws_exp            = 1'b0;
        bus.stop              = 1'b0;
        bus.icache_miss_pulse = 1'b0;
        bus.dcache_miss_pulse = 1'b0;
        bus.rd_req            = 1'b0;
    endtask

    task automatic retire(input entry_t e, input logic stopIn);
        applyStimulus(1'b1, e, stopIn, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic stopOnly();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic popReq();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic resetDut();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        entry_t e;
        bus.ws_valid = 1'b0; bus.ws_pc = '0; bus.ws_inst = '0;
        bus.ws_exp = 1'b0; bus.ws_mret = 1'b0; bus.ws_out_of_mem = 1'b0;
        bus.stop = 1'b0; bus.icache_miss_pulse = 1'b0; bus.dcache_miss_pulse = 1'b0;
        bus.rd_req = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        checkOutput("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
        checkOutput("reset_frozen", 64'(bus.frozen), 64'd0);
        checkOutput("reset_entry_cnt", 64'(bus.entry_cnt), 64'd0);
        checkOutput("reset_cycle_cnt", bus.cycle_cnt, 64'd0);
        checkOutput("reset_retire_cnt", bus.retire_cnt, 64'd0);
        checkOutput("reset_icache_cnt", 64'(bus.icache_miss_cnt), 64'd0);
        checkOutput("reset_dcache_cnt", 64'(bus.dcache_miss_cnt), 64'd0);
        checkOutput("reset_rd_pc", bus.rd_pc, 64'd0);

        // Five retirements, stop, six requests (last one reaches DONE).
        for (int k = 0; k < 5; k++) retire(makeEntry(k, 3'b000), 1'b0);
        stopOnly();
        @(negedge clk);
        checkOutput("t1_entry_cnt", 64'(bus.entry_cnt), 64'd5);
        checkOutput("t1_frozen", 64'(bus.frozen), 64'd1);
        for (int k = 0; k < 5; k++) begin
            expQ.push_back(makeEntry(k, 3'b000));
            popReq();
        end
        popReq();
        @(negedge clk);
        checkOutput("t1_empty_rd_valid", 64'(bus.rd_valid), 64'd0);
        checkOutput("t1_entry_cnt_drained", 64'(bus.entry_cnt), 64'd0);
        checkOutput("t1_retire_cnt", bus.retire_cnt, 64'd5);
        checkOutput("t1_cycle_cnt", bus.cycle_cnt, 64'd6);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("t1_done_icache_hold", 64'(bus.icache_miss_cnt), 64'd0);
        checkOutput("t1_done_dcache_hold", 64'(bus.dcache_miss_cnt), 64'd0);
        checkOutput("t1_done_frozen", 64'(bus.frozen), 64'd1);

        // Twenty retirements overflow the 16-entry ring; flags exercise bit order.
        resetDut();
        for (int k = 0; k < 20; k++) retire(makeEntry(k, {1'b0, k[1], k[0]}), 1'b0);
        stopOnly();
        @(negedge clk);
        checkOutput("t2_entry_cnt_full", 64'(bus.entry_cnt), 64'd16);
        checkOutput("t2_retire_cnt", bus.retire_cnt, 64'd20);
        checkOutput("t2_cycle_cnt", bus.cycle_cnt, 64'd21);
        for (int k = 4; k < 20; k++) begin
            expQ.push_back(makeEntry(k, {1'b0, k[1], k[0]}));
            popReq();
        end
        popReq();
        @(negedge clk);
        checkOutput("t2_entry_cnt_drained", 64'(bus.entry_cnt), 64'd0);

        // Stop together with a retirement into a full ring; later retirements are ignored.
        resetDut();
        for (int k = 0; k < 16; k++) retire(makeEntry(k, 3'b000), 1'b0);
        e = '{pc: 64'h8000_0100, inst: 32'h0010_0073, flags: 3'b000};
        retire(e, 1'b1);
        @(negedge clk);
        checkOutput("t3_frozen", 64'(bus.frozen), 64'd1);
        checkOutput("t3_entry_cnt", 64'(bus.entry_cnt), 64'd16);
        retire(makeEntry(99, 3'b011), 1'b0);
        @(negedge clk);
        checkOutput("t3_frozen_entry_cnt", 64'(bus.entry_cnt), 64'd16);
        checkOutput("t3_frozen_retire_cnt", bus.retire_cnt, 64'd17);
        checkOutput("t3_frozen_cycle_cnt", bus.cycle_cnt, 64'd17);
        for (int k = 1; k < 16; k++) begin
            expQ.push_back(makeEntry(k, 3'b000));
            popReq();
        end
        expQ.push_back(e);
        popReq();

        // Miss-counter saturation from a preloaded value.
        resetDut();
        @(negedge clk);
        force dut.icache_q = 32'hFFFF_FFFE;
        #1 release dut.icache_q;
        checkOutput("t4_icache_preload", 64'(bus.icache_miss_cnt), 64'hFFFF_FFFE);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t4_icache_saturated", 64'(bus.icache_miss_cnt), 64'hFFFF_FFFF);
        checkOutput("t4_dcache_one", 64'(bus.dcache_miss_cnt), 64'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t4_dcache_frozen_counts", 64'(bus.dcache_miss_cnt), 64'd3);

        // Reset arriving mid-drain, with a request pending on the same edge.
        resetDut();
        for (int k = 0; k < 4; k++) retire(makeEntry(k, 3'b000), 1'b0);
        stopOnly();
        for (int k = 0; k < 2; k++) begin
            expQ.push_back(makeEntry(k, 3'b000));
            popReq();
        end
        bus.rd_req = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.rd_req = 1'b0;
        @(negedge clk);
        checkOutput("t5_rd_valid", 64'(bus.rd_valid), 64'd0);
        checkOutput("t5_frozen", 64'(bus.frozen), 64'd0);
        checkOutput("t5_entry_cnt", 64'(bus.entry_cnt), 64'd0);
        checkOutput("t5_cycle_cnt", bus.cycle_cnt, 64'd0);
        checkOutput("t5_retire_cnt", bus.retire_cnt, 64'd0);
        retire(makeEntry(7, 3'b000), 1'b0);
        @(negedge clk);
        checkOutput("t5_new_entry_cnt", 64'(bus.entry_cnt), 64'd1);
        checkOutput("t5_new_retire_cnt", bus.retire_cnt, 64'd1);

        // Out-of-memory retirement with an exception flag.
        resetDut();
        e = '{pc: 64'h8000_0300, inst: 32'h0000_0073, flags: 3'b101};
        retire(e, 1'b0);
        @(negedge clk);
`ifdef COMMIT_TRACE_OOM_HALT_EN
        checkOutput("t6_oom_frozen", 64'(bus.frozen), 64'd1);
`else
        checkOutput("t6_oom_frozen", 64'(bus.frozen), 64'd0);
        stopOnly();
`endif
        @(negedge clk);
        checkOutput("t6_entry_cnt", 64'(bus.entry_cnt), 64'd1);
        expQ.push_back(e);
        popReq();

        @(negedge clk);
        @(negedge clk);
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
